// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
//   Memory-side responder for the data-cache refill / write-back interface.
//   Stores DEPTH lines of LINE_W bits and serves one line read or line write per
//   request. Every transaction completes LATENCY cycles after acceptance with a
//   single-cycle ack. Backing store used for cached-CPU simulation and bring-up.
//
// Ports
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset (memory contents are kept)
//   addr_i    : byte address of the line; bits [4:0] and bits above the index
//               are ignored, so addresses alias modulo DEPTH lines
//   data_i    : write line data
//   enable_i  : request valid, held by the initiator until ack
//   write_i   : 1 = line write, 0 = line read
//   ack_o     : one-cycle completion pulse
//   data_o    : read line data, valid with ack_o and held until the next read
//   busy_o    : high while a transaction is outstanding (WAIT and ACK)
//   rd_cnt_o  : completed reads, saturating
//   wr_cnt_o  : completed writes, saturating
// -----------------------------------------------------------------------------
module line_mem_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  // LATENCY is at most 255, so an 8-bit down-counter covers the whole range.
  localparam int LAT_W = 8;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt;

  // Request captured at acceptance; later input changes are ignored.
  logic [IDX_W-1:0]  r_idx_p0;
  logic              r_we_p0;
  logic [LINE_W-1:0] r_wdata_p0;

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_commit;

  // Byte-offset bits and bits above the line index carry no meaning here.
  logic              w_unused_addr;
  assign w_unused_addr = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

  assign w_idx    = addr_i[5+IDX_W-1:5];
  assign w_accept = (r_state == S_IDLE) && enable_i;
  assign w_commit = (r_state == S_WAIT) && (r_lat_cnt == '0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; ACK never samples inputs, which enforces one IDLE cycle
  // between back-to-back transactions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable_i) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_lat_cnt == '0) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack_o  = (r_state == S_ACK);
    busy_o = (r_state != S_IDLE);
  end

  // Latency counter: loaded with LATENCY-1 so the commit lands LATENCY edges
  // after acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                        r_lat_cnt <= '0;
    else if (w_accept)                                r_lat_cnt <= LAT_LOAD;
    else if (r_state == S_WAIT && r_lat_cnt != '0)    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
  end

  // ---- request capture (acceptance edge) ----
  always_ff @(posedge clk_i) begin
    if (w_accept && !rst_i) begin
      r_idx_p0   <= w_idx;
      r_we_p0    <= write_i;
      r_wdata_p0 <= data_i;
    end
  end

  // ---- commit (last WAIT edge) ----
  // Reset aborts an in-flight write before it reaches the array.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_we_p0 && !rst_i) r_mem[r_idx_p0] <= r_wdata_p0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                     r_rdata <= '0;
    else if (w_commit && !r_we_p0) r_rdata <= r_mem[r_idx_p0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_commit) begin
      if (r_we_p0) r_wr_cnt <= sat_inc(r_wr_cnt);
      else         r_rd_cnt <= sat_inc(r_rd_cnt);
    end
  end

  assign data_o   = r_rdata;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  logic         clk;
  // DUT A: LATENCY = 10
  logic         rst, en, we, ack, busy;
  logic [31:0]  addr;
  logic [255:0] wdata, rdata;
  logic [15:0]  rd_cnt, wr_cnt;
  // DUT B: LATENCY = 1
  logic         rst1, en1, we1, ack1, busy1;
  logic [31:0]  addr1;
  logic [255:0] wdata1, rdata1;
  logic [15:0]  rd_cnt1, wr_cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int lat, nbusy;

  line_mem_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(10), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en), .write_i(we),
    .ack_o(ack), .data_o(rdata), .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  line_mem_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(1), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .data_i(wdata1), .enable_i(en1), .write_i(we1),
    .ack_o(ack1), .data_o(rdata1), .busy_o(busy1), .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on DUT A, starting just after a rising edge with the
  // DUT idle. Returns edges from acceptance to ack and the number of busy
  // samples. With perturb set, addr/data/write are scrambled during WAIT.
  task automatic txn_a(input string tag, input logic w, input logic [31:0] a,
                       input logic [255:0] d, input bit perturb,
                       output int lat_o, output int nbusy_o);
    bit got;
    en = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    nbusy_o = busy ? 1 : 0;
    lat_o = 0;
    got = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (busy) nbusy_o++;
      if (ack) begin
        lat_o = k;
        got = 1'b1;
        break;
      end
      if (perturb) begin
        addr  = (k % 2 == 1) ? 32'h0000_00A0 : 32'h0000_20C0;
        wdata = {8{32'hDEAD_0000 + 32'(k)}};
        we    = k[0];
      end
    end
    if (!got) check({tag, "_timeout"}, 256'(got), 256'd1);
    en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_one_cycle"}, 256'(ack), 256'd0);
    check({tag, "_busy_end"}, 256'(busy), 256'd0);
  endtask

  initial begin
    int acks;
    logic [11:0] pat;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst1 = 1'b1; en1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Put a known value in line 0, then reset again: the array must survive.
    txn_a("pre_wr0", 1'b1, 32'h0, 256'h5, 1'b0, lat, nbusy);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ack", 256'(ack), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_data", rdata, 256'd0);
    check("rst_rd_cnt", 256'(rd_cnt), 256'd0);
    check("rst_wr_cnt", 256'(wr_cnt), 256'd0);

    txn_a("rd0", 1'b0, 32'h0, '0, 1'b0, lat, nbusy);
    check("rd0_latency", 256'(lat), 256'd10);
    check("rd0_busy_cycles", 256'(nbusy), 256'd11);
    check("rd0_data", rdata, 256'h5);
    check("rd0_rd_cnt", 256'(rd_cnt), 256'd1);

    txn_a("wr20", 1'b1, 32'h20, {32{8'hA5}}, 1'b0, lat, nbusy);
    check("wr20_latency", 256'(lat), 256'd10);
    check("wr20_data_held", rdata, 256'h5);
    check("wr20_wr_cnt", 256'(wr_cnt), 256'd1);
    txn_a("rd20", 1'b0, 32'h20, '0, 1'b0, lat, nbusy);
    check("rd20_data", rdata, {32{8'hA5}});
    check("rd20_rd_cnt", 256'(rd_cnt), 256'd2);
    check("rd20_wr_cnt", 256'(wr_cnt), 256'd1);

    txn_a("wr_alias", 1'b1, 32'h4040, 256'h1234, 1'b0, lat, nbusy);
    txn_a("rd40", 1'b0, 32'h40, '0, 1'b0, lat, nbusy);
    check("alias_data", rdata, 256'h1234);
    check("alias_rd_cnt", 256'(rd_cnt), 256'd3);

    // Reset in the fifth WAIT cycle of a write to line 3.
    txn_a("wr60_pre", 1'b1, 32'h60, 256'h3333, 1'b0, lat, nbusy);
    check("wr60_pre_wr_cnt", 256'(wr_cnt), 256'd3);
    en = 1'b1; we = 1'b1; addr = 32'h60; wdata = 256'hFF;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy_before", 256'(busy), 256'd1);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_ack", 256'(ack), 256'd0);
    check("mid_busy", 256'(busy), 256'd0);
    check("mid_rd_cnt", 256'(rd_cnt), 256'd0);
    check("mid_wr_cnt", 256'(wr_cnt), 256'd0);
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("mid_no_ack", 256'(acks), 256'd0);
    txn_a("rd60", 1'b0, 32'h60, '0, 1'b0, lat, nbusy);
    check("rd60_latency", 256'(lat), 256'd10);
    check("rd60_data", rdata, 256'h3333);
    check("rd60_rd_cnt", 256'(rd_cnt), 256'd1);

    // Inputs scrambled during WAIT must not affect the latched write.
    txn_a("wrA0", 1'b1, 32'hA0, 256'h5555, 1'b0, lat, nbusy);
    txn_a("wr80_pert", 1'b1, 32'h80, 256'hD0, 1'b1, lat, nbusy);
    check("pert_latency", 256'(lat), 256'd10);
    check("pert_wr_cnt", 256'(wr_cnt), 256'd2);
    check("pert_rd_cnt", 256'(rd_cnt), 256'd1);
    txn_a("rd80", 1'b0, 32'h80, '0, 1'b0, lat, nbusy);
    check("rd80_data", rdata, 256'hD0);
    txn_a("rdA0", 1'b0, 32'hA0, '0, 1'b0, lat, nbusy);
    check("rdA0_data", rdata, 256'h5555);
    check("rdA0_rd_cnt", 256'(rd_cnt), 256'd3);

    // DUT B, LATENCY = 1: enable held for three back-to-back reads.
    rst1 = 1'b0;
    en1 = 1'b1;
    acks = 0;
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      pat[k] = ack1;
      if (ack1) acks++;
      if (acks == 3) en1 = 1'b0;
    end
    check("b2b_ack_pattern", 256'(pat), 256'h092);
    check("b2b_ack_count", 256'(acks), 256'd3);
    check("b2b_rd_cnt", 256'(rd_cnt1), 256'd3);
    check("b2b_wr_cnt", 256'(wr_cnt1), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the data-cache refill/write-back interface. The data cache is the initiator; this block answers it.
- Holds DEPTH 256-bit lines and serves one line read or line write per request, with a fixed, parameterized latency and a single-cycle ack.
- Sits below the dcache at the CPU's mem_* ports. It is the programmable-latency backing store used in cached-CPU simulation and bring-up.

Parameters:
- LINE_W, 256, line width in bits (one cache block).
- ADDR_W, 32, byte-address width.
- DEPTH, 512, number of lines (16 KB); must be a power of 2.
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i, in, 1, clock; all logic on the rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- addr_i, in, ADDR_W, byte address of the line; bits [4:0] are ignored.
- data_i, in, LINE_W, write line data.
- enable_i, in, 1, request valid; held by the initiator until ack.
- write_i, in, 1, 1 = line write, 0 = line read.
- ack_o, out, 1, one-cycle completion pulse.
- data_o, out, LINE_W, read line data; valid while ack_o is high and held afterwards.
- busy_o, out, 1, high while a transaction is outstanding (states WAIT and ACK).
- rd_cnt_o, out, CNT_W, completed reads; saturating.
- wr_cnt_o, out, CNT_W, completed writes; saturating.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - state=IDLE; ack_o=0; busy_o=0; data_o=0; rd_cnt_o=0; wr_cnt_o=0; latency counter=0.
  - Memory array contents are NOT cleared, so testbench preloads survive reset.
- Line index = addr_i[5+log2(DEPTH)-1:5].
  - Address bits above the index are ignored, so addresses alias modulo DEPTH lines. This is not an error.
- State machine IDLE -> WAIT -> ACK -> IDLE.
- IDLE:
  - If enable_i=1 at an edge, latch index, write_i and data_i, load the counter with LATENCY-1, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Counter nonzero: decrement and stay in WAIT.
  - Counter zero: commit and go to ACK.
  - Commit for a write: mem[index] <= latched data.
  - Commit for a read: data_o <= mem[index].
  - Counter update: increment rd_cnt_o or wr_cnt_o, saturating at all-ones.
- ACK: ack_o=1 for exactly this one cycle; go to IDLE unconditionally.
- Latency: if acceptance happens at edge t0, the commit happens and ack_o rises at edge t0+LATENCY. ack_o is high for one cycle and low after edge t0+LATENCY+1.
  - LATENCY=1 gives ack_o high in the cycle right after acceptance.
- Input sampling: inputs are sampled only at acceptance. Changes to addr_i, data_i, write_i or enable_i during WAIT or ACK are ignored, including enable_i dropping (the transaction still completes).
- Back-to-back requests:
  - enable_i still high in the ACK cycle is not a new request, because ACK does not sample inputs.
  - A request is accepted at the first IDLE edge after ACK, so there is a minimum of one IDLE cycle between transactions.
- data_o is updated only on a read commit; writes leave it unchanged.
- Write then read of the same line: the read returns the newly written data.
- Reset mid-transaction (WAIT or ACK): abort, no memory write, no counter update, ack_o=0, state=IDLE.
- Reset wins over all other events in the same cycle.
- enable_i=1 together with rst_i=1: the request is not accepted; the initiator must keep it held to be served.

Test Plan:
- Reset, then read 0x0000 with mem[0]=256'h5 and LATENCY=10, enable_i held -> ack_o high exactly 10 cycles after the accept edge for one cycle; data_o=256'h5; rd_cnt_o=1; busy_o high for 11 cycles.
- Write 0x0020 with data 256'hA5A5…A5, then read 0x0020 -> read returns 256'hA5A5…A5; data_o unchanged during the write; wr_cnt_o=1, rd_cnt_o=1.
- Aliasing: write 0x4000+0x40 (index 2 with DEPTH=512) with data 256'h1234 -> mem[2]=256'h1234; a read of 0x0040 returns 256'h1234.
- Assert rst_i in WAIT cycle 5 of a write of 256'hFF to 0x0060 -> mem[3] unchanged; no ack_o; counters 0; state IDLE; the next read completes normally.
- LATENCY=1, enable_i held high continuously for 3 reads -> the ack_o pattern repeats every 3 cycles (accept, ACK, IDLE-accept); exactly 3 acks; rd_cnt_o=3.
- Change addr_i and data_i every cycle during WAIT of a write to 0x0080 -> only the values latched at acceptance are written to mem[4].
